mmc3_scanline_irq: RTL and testbench
====================================

// Module: mmc3_scanline_irq
// PURPOSE
//  MMC3-style scanline IRQ counter feeding the cartridge irq line of the CoolGirl top level.
//  Filters PPU A12 rising edges, counts them as scanlines and raises an IRQ request at zero.
//  Decodes the CPU register writes $C000/$C001/$E000/$E001 (romsel low).
//  Shared by the MMC3 family of mappers (#004, #118, #189); the top level ORs irq_pending
//  into its open-drain irq driver.
// PARAMETERS
//  A12_LOW_MIN   3  negedge-m2 cycles A12 must be low before a rise counts; range 1..15.
// PORTS
//  m2            in   1  CPU M2; the single clock; all flops update on its falling edge.
//  rst_n         in   1  async reset, active low.
//  enable        in   1  mapper selected; 0 = writes ignored, irq_pending forced 0.
//  romsel        in   1  CPU /ROMSEL, active low.
//  cpu_rw_in     in   1  CPU R/W; 0 = write.
//  cpu_addr_in   in  15  CPU A14..A0.
//  cpu_data_in   in   8  CPU data; sampled at the m2 falling edge.
//  ppu_a12       in   1  PPU A12, asynchronous to m2.
//  irq_pending   out  1  IRQ request, active high.
// BEHAVIOUR
//  Reset: counter=0, latch=0, reload_flag=0, irq_en=0, irq_pending=0, A12 sync=00, low_cnt=0.
//  - low_cnt=0 after reset: the first A12 rise needs a full filter interval.
//  Write strobe wr = enable & ~romsel & ~cpu_rw_in; register select = {A14,A13,A0}:
//  - 100 $C000  latch <= data.
//  - 101 $C001  counter <= 0 and reload_flag <= 1.
//  - 110 $E000  irq_en <= 0 and irq_pending <= 0.
//  - 111 $E001  irq_en <= 1.
//  - Every other select is ignored.
//  A12 path:
//  - 2-flop synchronizer, then low_cnt saturates at A12_LOW_MIN while synced A12 = 0.
//  - clk_evt = rising edge of synced A12 & (low_cnt == A12_LOW_MIN); low_cnt clears on A12 high.
//  On clk_evt:
//  - if counter==0 | reload_flag: counter <= latch and reload_flag <= 0.
//  - else counter <= counter-1 (8-bit, never wraps below 0).
//  - fire = (next counter == 0) & irq_en; fire sets irq_pending.
//  Same-cycle ordering:
//  - clk_evt uses the pre-write latch, flag and counter values.
//  - A $C001 write overrides the clk_evt counter result: counter=0, flag=1.
//  - $E000 beats fire: irq_pending=0. $E001 with fire: fire uses the old irq_en.
//  Latency:
//  - A12 rise to irq_pending high: 3 m2 falling edges (2 sync + 1 edge detect).
//  - $E000 write to irq_pending low: the same edge.
//  irq_pending holds until $E000, enable=0, or reset.
//  - enable=0 also freezes counter and flags but keeps the A12 filter running.
//  Reset asserted mid-operation clears all state immediately, asynchronously.
// CONFIGURATION
//  MMC3_IRQ_REV_A_EN defined (old MMC3A behaviour):
//  - fire additionally requires (counter_before != 0) | reload_flag.
//  - latch=0 fires once after $C001, then never again until the next $C001.
//  Undefined (MMC3B/C): fire on every clk_evt whose next counter is 0.
//  - latch=0 therefore fires on every scanline.
// STRUCTURE
//  Shared header mmc3_defs.vh: MMC3_REG_* select codes (3'b100..3'b111) and the counter width (8).
//  Sub-module a12_rise_filter (synchronizer + low_cnt + clk_evt), parameterized by A12_LOW_MIN.
//  Top block holds the register decode, counter, reload flag, irq_en and irq_pending.
// TESTING
//  1. $C000=3, $C001, $E001, then 5 A12 pulses (8 low/8 high m2 cycles each)
//     -> reload on pulse 1, counter 2,1,0 -> irq_pending rises 3 edges after pulse 4's rise.
//  2. A12 low only 2 cycles between rises (A12_LOW_MIN=3) -> no clk_evt; counter unchanged.
//  3. irq_pending=1, then $E000 -> low on the same edge; $E001 alone does not re-raise it.
//  4. latch=0, $C001, $E001, 3 pulses:
//     - rev B -> irq after each pulse, cleared by $E000 between pulses.
//     - MMC3_IRQ_REV_A_EN -> irq after pulse 1 only.
//  5. $C001 write on the same edge as clk_evt with counter=1 -> counter=0, flag=1, no irq.
//     - The next pulse reloads the latch.
//  6. rst_n pulsed low mid-count with irq_pending=1
//     -> all state 0 asynchronously; first post-reset rise needs 3 low cycles.

Source files
------------

// File: rtl/mmc3_scanline_irq_pkg.sv
// Shared definitions for the MMC3 scanline IRQ block: register select codes,
// counter width and the scanline counter step function.
package mmc3_scanline_irq_pkg;

  localparam int unsigned CNT_W = 8;

  typedef logic [CNT_W-1:0] counter_t;

  // Register select = {A14, A13, A0}
  localparam logic [2:0] MMC3_REG_LATCH   = 3'b100;
  localparam logic [2:0] MMC3_REG_RELOAD  = 3'b101;
  localparam logic [2:0] MMC3_REG_DISABLE = 3'b110;
  localparam logic [2:0] MMC3_REG_ENABLE  = 3'b111;

  // Counter value after one filtered A12 rise; reloading at zero keeps it from wrapping.
  function automatic counter_t counter_step(input counter_t counter, input counter_t latch,
                                            input logic reload_flag);
    if ((counter == '0) || reload_flag) begin
      return latch;
    end
    return counter - CNT_W'(1);
  endfunction

endpackage

// File: rtl/mmc3_scanline_irq_a12_rise_filter.sv
// PPU A12 synchronizer and low-time filter; clk_evt_c marks a rise that followed
// at least A12_LOW_MIN low cycles.
module mmc3_scanline_irq_a12_rise_filter #(
  parameter int unsigned A12_LOW_MIN = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a12,
  output logic clk_evt_c
);

  localparam int unsigned LOW_W   = 4;
  localparam logic [LOW_W-1:0] LOW_MIN = LOW_W'(A12_LOW_MIN);

  logic [1:0]       sync;
  logic [LOW_W-1:0] low_cnt;
  logic [LOW_W-1:0] low_cnt_next;

  // low_cnt only reaches LOW_MIN while synced A12 is low, so a match while high is a fresh rise
  always_comb begin
    low_cnt_next = low_cnt;
    if (sync[1]) begin
      low_cnt_next = '0;
    end else if (low_cnt != LOW_MIN) begin
      low_cnt_next = low_cnt + LOW_W'(1);
    end
  end

  assign clk_evt_c = sync[1] & (low_cnt == LOW_MIN);

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync    <= 2'b00;
      low_cnt <= '0;
    end else begin
      sync    <= {sync[0], a12};
      low_cnt <= low_cnt_next;
    end
  end

endmodule

// File: rtl/mmc3_scanline_irq.sv
// MMC3 scanline IRQ counter: CPU register decode, counter, reload flag and IRQ request.
// Define MMC3_IRQ_REV_A_EN for the MMC3A firing rule (no refire while the counter stays zero).
module mmc3_scanline_irq
  import mmc3_scanline_irq_pkg::*;
#(
  parameter int unsigned A12_LOW_MIN = 3
) (
  input  logic        m2,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        romsel,
  input  logic        cpu_rw_in,
  input  logic [14:0] cpu_addr_in,
  input  logic [7:0]  cpu_data_in,
  input  logic        ppu_a12,
  output logic        irq_pending
);

  counter_t counter, counter_next;
  counter_t latch, latch_next;
  counter_t counter_evt;
  logic     reload_flag, reload_flag_next;
  logic     irq_en, irq_en_next;
  logic     irq_pending_next;
  logic     clk_evt_c;
  logic     evt;
  logic     fire;
  logic     wr;
  logic [2:0] sel;
  logic     wr_latch, wr_reload, wr_disable, wr_enable;
  logic     unused_addr_bits;

  mmc3_scanline_irq_a12_rise_filter #(
    .A12_LOW_MIN(A12_LOW_MIN)
  ) u_filter (
    .clk      (m2),
    .rst_n    (rst_n),
    .a12      (ppu_a12),
    .clk_evt_c(clk_evt_c)
  );

  assign unused_addr_bits = ^cpu_addr_in[12:1];

  assign wr         = enable & ~romsel & ~cpu_rw_in;
  assign sel        = {cpu_addr_in[14], cpu_addr_in[13], cpu_addr_in[0]};
  assign wr_latch   = wr & (sel == MMC3_REG_LATCH);
  assign wr_reload  = wr & (sel == MMC3_REG_RELOAD);
  assign wr_disable = wr & (sel == MMC3_REG_DISABLE);
  assign wr_enable  = wr & (sel == MMC3_REG_ENABLE);

  // Counter events are frozen while the mapper is deselected
  assign evt         = enable & clk_evt_c;
  assign counter_evt = counter_step(counter, latch, reload_flag);

  // A same-edge $C001 zeroes the counter without requesting an IRQ
`ifdef MMC3_IRQ_REV_A_EN
  assign fire = evt & (counter_evt == '0) & irq_en & ~wr_reload
              & ((counter != '0) | reload_flag);
`else
  assign fire = evt & (counter_evt == '0) & irq_en & ~wr_reload;
`endif

  always_comb begin
    counter_next     = counter;
    latch_next       = latch;
    reload_flag_next = reload_flag;
    irq_en_next      = irq_en;
    irq_pending_next = irq_pending;

    if (evt) begin
      counter_next     = counter_evt;
      reload_flag_next = 1'b0;
    end
    if (wr_latch) begin
      latch_next = cpu_data_in;
    end
    if (wr_reload) begin
      counter_next     = '0;
      reload_flag_next = 1'b1;
    end
    if (wr_disable) begin
      irq_en_next = 1'b0;
    end
    if (wr_enable) begin
      irq_en_next = 1'b1;
    end

    if (!enable || wr_disable) begin
      irq_pending_next = 1'b0;
    end else if (fire) begin
      irq_pending_next = 1'b1;
    end
  end

  always_ff @(negedge m2 or negedge rst_n) begin
    if (!rst_n) begin
      counter     <= '0;
      latch       <= '0;
      reload_flag <= 1'b0;
      irq_en      <= 1'b0;
      irq_pending <= 1'b0;
    end else begin
      counter     <= counter_next;
      latch       <= latch_next;
      reload_flag <= reload_flag_next;
      irq_en      <= irq_en_next;
      irq_pending <= irq_pending_next;
    end
  end

endmodule

// File: tb/tb_mmc3_scanline_irq.sv
// Directed bench for mmc3_scanline_irq: register/pulse vector table plus hand-written
// sequences for latency, filter boundary, same-edge reload, enable and reset.
module tb_mmc3_scanline_irq;

`ifdef MMC3_IRQ_REV_A_EN
  localparam bit REV_A = 1'b1;
`else
  localparam bit REV_A = 1'b0;
`endif

  localparam logic [14:0] A_C000 = 15'h4000;
  localparam logic [14:0] A_C001 = 15'h4001;
  localparam logic [14:0] A_E000 = 15'h6000;
  localparam logic [14:0] A_E001 = 15'h6001;

  logic        m2;
  logic        rst_n;
  logic        enable;
  logic        romsel;
  logic        cpu_rw_in;
  logic [14:0] cpu_addr_in;
  logic [7:0]  cpu_data_in;
  logic        ppu_a12;
  logic        irq_pending;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit          is_pulse;
    logic [14:0] addr;
    logic [7:0]  data;
    logic [7:0]  e_latch;
    logic [7:0]  e_cnt;
    logic        e_flag;
    logic        e_en;
    logic        e_pend;
  } vec_t;

  vec_t vecs[$];

  mmc3_scanline_irq #(.A12_LOW_MIN(3)) dut (
    .m2         (m2),
    .rst_n      (rst_n),
    .enable     (enable),
    .romsel     (romsel),
    .cpu_rw_in  (cpu_rw_in),
    .cpu_addr_in(cpu_addr_in),
    .cpu_data_in(cpu_data_in),
    .ppu_a12    (ppu_a12),
    .irq_pending(irq_pending)
  );

  initial m2 = 1'b1;
  always #5 m2 = ~m2;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One falling edge of m2, returning on the following rising edge
  task automatic tick();
    @(negedge m2);
    @(posedge m2);
  endtask

  task automatic cpu_write(input logic [14:0] a, input logic [7:0] d);
    cpu_addr_in = a;
    cpu_data_in = d;
    romsel      = 1'b0;
    cpu_rw_in   = 1'b0;
    tick();
    romsel      = 1'b1;
    cpu_rw_in   = 1'b1;
  endtask

  task automatic a12_run(input logic level, input int n);
    ppu_a12 = level;
    repeat (n) tick();
  endtask

  task automatic pulse();
    a12_run(1'b0, 8);
    a12_run(1'b1, 8);
  endtask

  function automatic vec_t mk(input bit p, input logic [14:0] a, input logic [7:0] d,
                              input logic [7:0] l, input logic [7:0] c, input logic f,
                              input logic e, input logic q);
    vec_t v;
    v.is_pulse = p; v.addr = a; v.data = d;
    v.e_latch = l; v.e_cnt = c; v.e_flag = f; v.e_en = e; v.e_pend = q;
    return v;
  endfunction

  task automatic check_state(input string tag, input logic [7:0] l, input logic [7:0] c,
                             input logic f, input logic e, input logic q);
    check({tag, " latch"},   dut.latch, l);
    check({tag, " counter"}, dut.counter, c);
    check({tag, " flag"},    8'(dut.reload_flag), 8'(f));
    check({tag, " irq_en"},  8'(dut.irq_en), 8'(e));
    check({tag, " pending"}, 8'(irq_pending), 8'(q));
  endtask

  initial begin
    rst_n       = 1'b0;
    enable      = 1'b1;
    romsel      = 1'b1;
    cpu_rw_in   = 1'b1;
    cpu_addr_in = '0;
    cpu_data_in = '0;
    ppu_a12     = 1'b0;

    // Basic count/reload, ignored selects, mirrored addresses, latch=0 behaviour
    vecs.push_back(mk(0, A_C000, 8'd3, 8'd3, 8'd0, 0, 0, 0));
    vecs.push_back(mk(0, A_C001, 8'd0, 8'd3, 8'd0, 1, 0, 0));
    vecs.push_back(mk(0, A_E001, 8'd0, 8'd3, 8'd0, 1, 1, 0));
    vecs.push_back(mk(1, '0,     8'd0, 8'd3, 8'd3, 0, 1, 0));
    vecs.push_back(mk(1, '0,     8'd0, 8'd3, 8'd2, 0, 1, 0));
    vecs.push_back(mk(1, '0,     8'd0, 8'd3, 8'd1, 0, 1, 0));
    vecs.push_back(mk(1, '0,     8'd0, 8'd3, 8'd0, 0, 1, 1));
    vecs.push_back(mk(1, '0,     8'd0, 8'd3, 8'd3, 0, 1, 1));
    vecs.push_back(mk(0, A_E000, 8'd0, 8'd3, 8'd3, 0, 0, 0));
    vecs.push_back(mk(0, 15'h0000, 8'h55, 8'd3, 8'd3, 0, 0, 0));
    vecs.push_back(mk(0, 15'h2001, 8'h55, 8'd3, 8'd3, 0, 0, 0));
    vecs.push_back(mk(0, 15'h5FFE, 8'd0, 8'd0, 8'd3, 0, 0, 0));
    vecs.push_back(mk(0, 15'h7FFF, 8'd0, 8'd0, 8'd3, 0, 1, 0));
    vecs.push_back(mk(0, A_C001, 8'd0, 8'd0, 8'd0, 1, 1, 0));
    vecs.push_back(mk(1, '0,     8'd0, 8'd0, 8'd0, 0, 1, 1));
    vecs.push_back(mk(0, A_E000, 8'd0, 8'd0, 8'd0, 0, 0, 0));
    vecs.push_back(mk(0, A_E001, 8'd0, 8'd0, 8'd0, 0, 1, 0));
    vecs.push_back(mk(1, '0,     8'd0, 8'd0, 8'd0, 0, 1, !REV_A));
    vecs.push_back(mk(0, A_E000, 8'd0, 8'd0, 8'd0, 0, 0, 0));
    vecs.push_back(mk(0, A_E001, 8'd0, 8'd0, 8'd0, 0, 1, 0));
    vecs.push_back(mk(1, '0,     8'd0, 8'd0, 8'd0, 0, 1, !REV_A));

    tick();
    tick();
    rst_n = 1'b1;
    check_state("reset", 8'd0, 8'd0, 0, 0, 0);
    check("reset low_cnt", 8'(dut.u_filter.low_cnt), 8'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].is_pulse) pulse();
      else cpu_write(vecs[i].addr, vecs[i].data);
      check_state($sformatf("v%0d", i), vecs[i].e_latch, vecs[i].e_cnt,
                  vecs[i].e_flag, vecs[i].e_en, vecs[i].e_pend);
    end

    // A12 rise to irq_pending: exactly three falling edges
    cpu_write(A_E000, 8'd0);
    cpu_write(A_C000, 8'd1);
    cpu_write(A_C001, 8'd0);
    cpu_write(A_E001, 8'd0);
    pulse();
    check("lat counter", dut.counter, 8'd1);
    a12_run(1'b0, 8);
    ppu_a12 = 1'b1;
    tick();
    check("lat edge1", 8'(irq_pending), 8'd0);
    tick();
    check("lat edge2", 8'(irq_pending), 8'd0);
    tick();
    check("lat edge3", 8'(irq_pending), 8'd1);
    a12_run(1'b1, 7);

    // Filter boundary: 2 low cycles rejected, 3 accepted
    cpu_write(A_E000, 8'd0);
    cpu_write(A_C000, 8'd5);
    cpu_write(A_C001, 8'd0);
    cpu_write(A_E001, 8'd0);
    pulse();
    check("flt reload", dut.counter, 8'd5);
    a12_run(1'b0, 2);
    a12_run(1'b1, 8);
    check("flt low2", dut.counter, 8'd5);
    a12_run(1'b0, 3);
    a12_run(1'b1, 8);
    check("flt low3", dut.counter, 8'd4);

    // $E000 clears on its own edge; $E001 does not re-raise
    cpu_write(A_E000, 8'd0);
    cpu_write(A_C000, 8'd1);
    cpu_write(A_C001, 8'd0);
    cpu_write(A_E001, 8'd0);
    pulse();
    pulse();
    check("ack pending", 8'(irq_pending), 8'd1);
    cpu_addr_in = A_E000;
    romsel      = 1'b0;
    cpu_rw_in   = 1'b0;
    tick();
    romsel      = 1'b1;
    cpu_rw_in   = 1'b1;
    check("ack cleared", 8'(irq_pending), 8'd0);
    cpu_write(A_E001, 8'd0);
    check("ack e001", 8'(irq_pending), 8'd0);
    check("ack en", 8'(dut.irq_en), 8'd1);
    pulse();
    check("ack reload", 8'(irq_pending), 8'd0);

    // $C001 on the same edge as clk_evt with counter=1
    cpu_write(A_E000, 8'd0);
    cpu_write(A_C000, 8'd2);
    cpu_write(A_C001, 8'd0);
    cpu_write(A_E001, 8'd0);
    pulse();
    pulse();
    check("same cnt1", dut.counter, 8'd1);
    a12_run(1'b0, 8);
    ppu_a12 = 1'b1;
    tick();
    tick();
    cpu_write(A_C001, 8'd0);
    check_state("same edge", 8'd2, 8'd0, 1, 1, 0);
    a12_run(1'b1, 5);
    pulse();
    check_state("same next", 8'd2, 8'd2, 0, 1, 0);

    // enable=0 drops the request and freezes the register file
    cpu_write(A_E000, 8'd0);
    cpu_write(A_C000, 8'd0);
    cpu_write(A_C001, 8'd0);
    cpu_write(A_E001, 8'd0);
    pulse();
    check("en pending", 8'(irq_pending), 8'd1);
    enable = 1'b0;
    tick();
    check("en off", 8'(irq_pending), 8'd0);
    cpu_write(A_C000, 8'd7);
    check("en latch", dut.latch, 8'd0);
    pulse();
    check("en frozen", 8'(irq_pending), 8'd0);
    enable = 1'b1;
    pulse();
    check("en back", 8'(irq_pending), 8'(!REV_A));

    // Asynchronous reset mid-count with a pending request
    cpu_write(A_E000, 8'd0);
    cpu_write(A_C000, 8'd1);
    cpu_write(A_C001, 8'd0);
    cpu_write(A_E001, 8'd0);
    pulse();
    pulse();
    cpu_write(A_C000, 8'd5);
    check("rst pre", 8'(irq_pending), 8'd1);
    a12_run(1'b0, 4);
    ppu_a12 = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check_state("rst async", 8'd0, 8'd0, 0, 0, 0);
    check("rst low_cnt", 8'(dut.u_filter.low_cnt), 8'd0);
    check("rst sync", 8'(dut.u_filter.sync), 8'd0);
    @(posedge m2);
    rst_n = 1'b1;
    cpu_write(A_C001, 8'd0);
    cpu_write(A_E001, 8'd0);
    a12_run(1'b1, 3);
    check("rst no evt", 8'(irq_pending), 8'd0);
    a12_run(1'b0, 3);
    a12_run(1'b1, 4);
    check("rst first evt", 8'(irq_pending), 8'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
